// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: decode inputs and datapath control outputs of the multicycle control unit
interface mc_control_fsm_if;
   logic [6:0] op;
   logic [2:0] f3;
   logic       f7;
   logic       zero;
   logic       memReady;
   logic       pcWrite;
   logic       adrSrc;
   logic       memWrite;
   logic       irWrite;
   logic [1:0] resSrc;
   logic [2:0] ALUControl;
   logic [1:0] aluSrcA;
   logic [1:0] aluSrcB;
   logic [1:0] inmSrc;
   logic       regWrite;
   logic       illegal;
   logic [3:0] state;
   modport master (
      output op, f3, f7, zero, memReady,
      input  pcWrite, adrSrc, memWrite, irWrite, resSrc, ALUControl,
             aluSrcA, aluSrcB, inmSrc, regWrite, illegal, state
   );
   modport slave (
      input  op, f3, f7, zero, memReady,
      output pcWrite, adrSrc, memWrite, irWrite, resSrc, ALUControl,
             aluSrcA, aluSrcB, inmSrc, regWrite, illegal, state
   );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle RV32 subset control unit (lw/sw/R/I/beq/bne/jal)
module mc_control_fsm (
   input logic         clk,
   input logic         reset,
   mc_control_fsm_if.slave bus
);
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BRANCH, JAL
   } state_t;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_J  = 7'b1101111;
   state_t     st, nx;
   logic       pc_w, adr, mem_w, ir_w, reg_w, ill, ill_f;
   logic [1:0] res, sa, sb;
   logic [2:0] alu, alu_f;
   always_ff @(posedge clk or posedge reset)
      if (reset) st <= FETCH;
      else st <= nx;
   assign alu_f = bus.f3 == 3'b000 ? ((bus.op[5] & bus.f7) ? 3'b001 : 3'b000) :
                  bus.f3 == 3'b100 ? 3'b100 :
                  bus.f3 == 3'b010 ? 3'b101 :
                  bus.f3 == 3'b110 ? 3'b011 :
                  bus.f3 == 3'b111 ? 3'b010 : 3'b000;
   assign ill_f = bus.f3[0] & ~(bus.f3[2] & bus.f3[1]);
   always_comb begin
      nx    = FETCH;
      pc_w  = 1'b0;
      adr   = 1'b0;
      mem_w = 1'b0;
      ir_w  = 1'b0;
      reg_w = 1'b0;
      ill   = 1'b0;
      res   = 2'b00;
      alu   = 3'b000;
      sa    = 2'b00;
      sb    = 2'b00;
      case (st)
         FETCH: begin
            sb   = 2'b10;
            res  = 2'b10;
            ir_w = bus.memReady;
            pc_w = bus.memReady;
            nx   = bus.memReady ? DECODE : FETCH;
         end
         DECODE: begin
            sa  = 2'b01;
            sb  = 2'b01;
            nx  = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                  bus.op == OP_R  ? EXECR :
                  bus.op == OP_I  ? EXECI :
                  bus.op == OP_BR ? BRANCH :
                  bus.op == OP_J  ? JAL : FETCH;
            ill = nx == FETCH;
         end
         MEMADR: begin
            sa = 2'b10;
            sb = 2'b01;
            nx = bus.op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adr = 1'b1;
            nx  = bus.memReady ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            res   = 2'b01;
            reg_w = 1'b1;
         end
         MEMWRITE: begin
            adr   = 1'b1;
            mem_w = bus.memReady;
            nx    = bus.memReady ? FETCH : MEMWRITE;
         end
         EXECR: begin
            sa  = 2'b10;
            alu = alu_f;
            ill = ill_f;
            nx  = ALUWB;
         end
         EXECI: begin
            sa  = 2'b10;
            sb  = 2'b01;
            alu = alu_f;
            ill = ill_f;
            nx  = ALUWB;
         end
         ALUWB: reg_w = 1'b1;
         BRANCH: begin
            sa   = 2'b10;
            alu  = 3'b001;
            pc_w = bus.zero ^ bus.f3[0];
         end
         JAL: begin
            sa   = 2'b01;
            sb   = 2'b10;
            pc_w = 1'b1;
            nx   = ALUWB;
         end
         default: nx = FETCH;
      endcase
   end
   // reset kills every strobe combinationally so an in-flight write never lands
   assign bus.pcWrite    = pc_w & ~reset;
   assign bus.irWrite    = ir_w & ~reset;
   assign bus.memWrite   = mem_w & ~reset;
   assign bus.regWrite   = reg_w & ~reset;
   assign bus.illegal    = ill & ~reset;
   assign bus.adrSrc     = adr;
   assign bus.resSrc     = res;
   assign bus.ALUControl = alu;
   assign bus.aluSrcA    = sa;
   assign bus.aluSrcB    = sb;
   assign bus.inmSrc     = bus.op == OP_SW ? 2'b01 :
                           bus.op == OP_BR ? 2'b10 :
                           bus.op == OP_J  ? 2'b11 : 2'b00;
   assign bus.state      = st;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed instruction sequences, expected control vectors checked by a negedge monitor
module tb_mc_control_fsm;
   localparam logic [6:0] R  = 7'b0110011;
   localparam logic [6:0] I  = 7'b0010011;
   localparam logic [6:0] LW = 7'b0000011;
   localparam logic [6:0] SW = 7'b0100011;
   localparam logic [6:0] BR = 7'b1100011;
   localparam logic [6:0] J  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;
   typedef struct {
      logic [20:0] v;
      string       tag;
   } exp_t;
   logic  clk = 1'b0;
   logic  reset = 1'b1;
   int    checks = 0;
   int    errors = 0;
   string tag = "reset";
   exp_t  q[$];
   logic [20:0] act;
   mc_control_fsm_if bus ();
   mc_control_fsm dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   assign act = {bus.state, bus.pcWrite, bus.adrSrc, bus.memWrite, bus.irWrite, bus.resSrc,
                 bus.ALUControl, bus.aluSrcA, bus.aluSrcB, bus.inmSrc, bus.regWrite, bus.illegal};
   function automatic logic [20:0] pack(input logic [3:0] s, input logic pcw, adr, mw, irw,
                                        input logic [1:0] res, input logic [2:0] alu,
                                        input logic [1:0] sa, sb, inm, input logic rw, il);
      return {s, pcw, adr, mw, irw, res, alu, sa, sb, inm, rw, il};
   endfunction
   task automatic drv(input logic [6:0] o, input logic [2:0] a, input logic b, z, m);
      bus.op = o;
      bus.f3 = a;
      bus.f7 = b;
      bus.zero = z;
      bus.memReady = m;
   endtask
   // queue the expected vector for this cycle, then advance to just past the next edge
   task automatic e(input logic [3:0] s, input logic pcw, adr, mw, irw, input logic [1:0] res,
                    input logic [2:0] alu, input logic [1:0] sa, sb, inm, input logic rw, il);
      exp_t x;
      x.v = pack(s, pcw, adr, mw, irw, res, alu, sa, sb, inm, rw, il);
      x.tag = tag;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (act !== x.v) begin
               errors++;
               $display("FAIL %s: got %h expected %h", x.tag, act, x.v);
            end
         end
      end
   end
   initial begin
      drv(R, 3'b000, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      e(0, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0, 0);
      reset = 1'b0;
      tag = "add";
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      e(6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tag = "sub";
      drv(R, 3'b000, 1'b1, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      e(6, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tag = "addi_f7";
      drv(I, 3'b000, 1'b1, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      e(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tag = "xori";
      drv(I, 3'b100, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      e(7, 0, 0, 0, 0, 0, 4, 2, 1, 0, 0, 0);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tag = "slt_or_and";
      drv(R, 3'b010, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      e(6, 0, 0, 0, 0, 0, 5, 2, 0, 0, 0, 0);
      drv(R, 3'b110, 1'b0, 1'b0, 1'b1);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      e(6, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 0);
      drv(I, 3'b111, 1'b0, 1'b0, 1'b1);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      e(7, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tag = "bad_f3";
      drv(I, 3'b001, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      e(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 1);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tag = "lw_wait";
      drv(LW, 3'b010, 1'b0, 1'b0, 1'b0);
      e(0, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0, 0);
      drv(LW, 3'b010, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      drv(LW, 3'b010, 1'b0, 1'b0, 1'b0);
      e(2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
      e(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      drv(LW, 3'b010, 1'b0, 1'b0, 1'b1);
      e(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
      tag = "sw_wait";
      drv(SW, 3'b010, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 1, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      drv(SW, 3'b010, 1'b0, 1'b0, 1'b0);
      e(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      e(5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      drv(SW, 3'b010, 1'b0, 1'b0, 1'b1);
      e(5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
      tag = "bne_z0";
      drv(BR, 3'b001, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 2, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
      e(9, 1, 0, 0, 0, 0, 1, 2, 0, 2, 0, 0);
      tag = "bne_z1";
      drv(BR, 3'b001, 1'b0, 1'b1, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 2, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
      e(9, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0, 0);
      tag = "beq_z1";
      drv(BR, 3'b000, 1'b0, 1'b1, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 2, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
      e(9, 1, 0, 0, 0, 0, 1, 2, 0, 2, 0, 0);
      tag = "jal";
      drv(J, 3'b000, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 3, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0);
      e(10, 1, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0);
      e(8, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0);
      tag = "illegal_op";
      drv(BAD, 3'b000, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      tag = "rst_in_memwrite";
      drv(SW, 3'b010, 1'b0, 1'b0, 1'b1);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      e(2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      checks++;
      if (act !== pack(5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0)) begin
         errors++;
         $display("FAIL memwrite_pre_rst: got %h expected %h", act,
                  pack(5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
      end
      reset = 1'b1;
      e(0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 0);
      tag = "rst_hold";
      e(0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 0, 0);
      reset = 1'b0;
      tag = "after_rst";
      drv(R, 3'b000, 1'b0, 1'b0, 1'b1);
      e(0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
      e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int k = 0; k < 4 && q.size() > 0; k++) @(posedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have no parameters; encodings are fixed by this document.
REQ-002 The block SHALL have these ports:
- clk  in  1  the only clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH immediately.
- op  in  7  instruction opcode from the instruction register.
- f3  in  3  funct3.
- f7  in  1  funct7 bit 5.
- zero  in  1  ALU zero flag.
- memReady  in  1  memory access completes this cycle.
- pcWrite  out  1  PC register enable.
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- memWrite  out  1  data memory write strobe.
- irWrite  out  1  instruction register enable.
- resSrc  out  2  result mux select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- aluSrcA  out  2  00 = PC, 01 = oldPC, 10 = rs1.
- aluSrcB  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
- inmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- regWrite  out  1  register file write enable.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state code, for debug.

Function
REQ-003 The state codes SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10.
- Codes 11-15 SHALL go to FETCH on the next edge.
REQ-004 All outputs SHALL be Moore functions of state, except these:
- inmSrc, ALUControl and illegal also depend on op/f3/f7.
- In FETCH/MEMREAD/MEMWRITE, irWrite, pcWrite and memWrite are gated by memReady.
- In BRANCH, pcWrite is gated by the branch condition.
REQ-005 Any output not listed for a state SHALL be 0.
REQ-006 FETCH:
- adrSrc=0, aluSrcA=00, aluSrcB=10, add, resSrc=10.
- irWrite=pcWrite=memReady.
- Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
REQ-007 DECODE:
- aluSrcA=01, aluSrcB=01, add (computes branch target).
- Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - otherwise -> FETCH with illegal=1 for this cycle.
REQ-008 MEMADR:
- aluSrcA=10, aluSrcB=01, add.
- op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
REQ-009 MEMREAD:
- adrSrc=1, resSrc=00.
- Holds while memReady=0; then -> MEMWB.
REQ-010 MEMWB: resSrc=01, regWrite=1, -> FETCH.
REQ-011 MEMWRITE:
- adrSrc=1, resSrc=00, memWrite=memReady.
- Holds while memReady=0; then -> FETCH.
REQ-012 EXECR: aluSrcA=10, aluSrcB=00, function-decoded ALU, -> ALUWB.
REQ-013 EXECI: aluSrcA=10, aluSrcB=01, function-decoded ALU, -> ALUWB.
REQ-014 ALUWB: resSrc=00, regWrite=1, -> FETCH.
REQ-015 BRANCH:
- aluSrcA=10, aluSrcB=00, sub, resSrc=00.
- pcWrite = zero XOR f3[0] (beq/bne).
- -> FETCH.
REQ-016 JAL:
- aluSrcA=01, aluSrcB=10, add, resSrc=00, pcWrite=1.
- -> ALUWB (writes PC+4 to rd).
REQ-017 Function decode (EXECR/EXECI) by f3:
- 000: sub if op[5]=1 and f7=1, else add.
- 100 -> xor; 010 -> slt; 110 -> or; 111 -> and.
- Other f3 -> add, with illegal=1 in that execute state.
REQ-018 inmSrc SHALL decode from op in every state:
- store -> 01; branch -> 10; jal -> 11; all others -> 00.
REQ-019 Latency in cycles (memReady held high): R/I = 4, lw = 5, sw = 4, branch = 3, jal = 4.
- Each memReady=0 cycle adds exactly one cycle.

Reset
REQ-020 While reset=1:
- state SHALL be FETCH.
- pcWrite, irWrite, memWrite, regWrite and illegal SHALL be 0, regardless of memReady.
- All other outputs SHALL hold their FETCH values.
REQ-021 After reset deasserts, the first rising edge SHALL evaluate FETCH normally.
REQ-022 Reset asserted mid-instruction (e.g. in MEMWRITE with memReady=1) SHALL drop memWrite combinationally and suppress the write.

Verification
REQ-023 add (op=0110011, f3=000, f7=0), memReady=1 -> states 0,1,6,8,0; ALUControl=000 in EXECR; regWrite=1 only in ALUWB.
REQ-024 lw with memReady=0 for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; resSrc=01 and regWrite=1 in MEMWB.
REQ-025 bne (f3=001) with zero=0 -> pcWrite=1 in BRANCH; same with zero=1 -> pcWrite=0; both return to 0.
REQ-026 op=1111111 -> illegal=1 in DECODE for one cycle, next state 0, no regWrite/memWrite asserted.
REQ-027 Reset raised while in MEMWRITE with memReady=1 -> memWrite=0 in the same cycle, state=0.
REQ-028 sub (f7=1, op=0110011) vs addi with f7=1 (op=0010011) -> ALUControl 001 vs 000.
